// File: rtl/regfile_mp_sb_if.sv
// Decode/writeback bus of the parametrised register file with scoreboard.
// The master side is the pipeline; the slave side is regfile_mp_sb.
interface regfile_mp_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              clear_req;
    logic              busy;
    logic [ADDR_W-1:0] rd_addr1;
    logic [DATA_W-1:0] rd_data1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              sb_set_en;
    logic [ADDR_W-1:0] sb_set_addr;
    logic              sb_pend1;
    logic              sb_pend2;

    modport master (
        output clear_req, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
               sb_set_en, sb_set_addr,
        input  busy, rd_data1, rd_data2, sb_pend1, sb_pend2
    );

    modport slave (
        input  clear_req, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
               sb_set_en, sb_set_addr,
        output busy, rd_data1, rd_data2, sb_pend1, sb_pend2
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// 2-read/1-write register file with pending-write scoreboard and a sequenced clear sweep.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    regfile_mp_sb_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  cnt_q;
    logic               busy_q;
    logic [DEPTH-1:0]   sb_q;
    logic [DEPTH-1:0]   sb_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic               idle;
    logic               wr_ok;
    logic               set_ok;
    logic [ADDR_W-1:0]  rd_addr [2];

    assign idle   = (state_q == S_IDLE);
    assign wr_ok  = idle && bus.wr_en && !(ZERO_REG && (bus.wr_addr == '0));
    assign set_ok = idle && bus.sb_set_en && !(ZERO_REG && (bus.sb_set_addr == '0));

    assign rd_addr[0] = bus.rd_addr1;
    assign rd_addr[1] = bus.rd_addr2;

    // Set is applied after clear so a new producer supersedes a retiring one.
    always_comb begin
        sb_d = sb_q;
        if (wr_ok) begin
            sb_d[bus.wr_addr] = 1'b0;
        end
        if (set_ok) begin
            sb_d[bus.sb_set_addr] = 1'b1;
        end
        if (ZERO_REG) begin
            sb_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            sb_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.clear_req) begin
                        state_q <= S_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        sb_q    <= '0;
                    end else begin
                        sb_q <= sb_d;
                    end
                end
                S_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_CLEAR;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                    sb_q    <= '0;
                end
            endcase
        end
    end

    // Storage has no reset; the sweep zeroes one entry per cycle instead.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_ok) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic              zero_hit;
            logic [DATA_W-1:0] data_c;
            logic              pend_c;

            assign zero_hit = ZERO_REG && (rd_addr[gi] == '0);

`ifdef REGFILE_BYPASS_EN
            logic fwd;
            assign fwd = wr_ok && (rd_addr[gi] == bus.wr_addr);

            always_comb begin
                data_c = '0;
                pend_c = 1'b0;
                if (idle && !zero_hit) begin
                    if (fwd) begin
                        data_c = bus.wr_data;
                        pend_c = set_ok && (bus.sb_set_addr == rd_addr[gi]);
                    end else begin
                        data_c = mem_q[rd_addr[gi]];
                        pend_c = sb_q[rd_addr[gi]];
                    end
                end
            end
`else
            always_comb begin
                data_c = '0;
                pend_c = 1'b0;
                if (idle && !zero_hit) begin
                    data_c = mem_q[rd_addr[gi]];
                    pend_c = sb_q[rd_addr[gi]];
                end
            end
`endif
        end
    endgenerate

    assign bus.busy     = busy_q;
    assign bus.rd_data1 = g_rd[0].data_c;
    assign bus.rd_data2 = g_rd[1].data_c;
    assign bus.sb_pend1 = g_rd[0].pend_c;
    assign bus.sb_pend2 = g_rd[1].pend_c;

endmodule
